// File: rtl/cordic_angle_sweeper.sv
// cordic_angle_sweeper
// Steps through integer-degree angles, issues one CORDIC request per angle,
// waits for the result and forwards it, tagged with its angle, on a
// valid/ready stream. Supports one-shot (single revolution) and continuous
// sweeps.
//
// Optional build macro: SWEEP_TIMEOUT_EN
//   Defined   : a WAIT watchdog abandons a request after TIMEOUT_CYCLES,
//               emits a zero sample and sets the sticky timeout_err flag.
//   Undefined : WAIT waits indefinitely and timeout_err is tied low.
module cordic_angle_sweeper #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        continuous,
    input  logic [8:0]  start_angle,
    input  logic [8:0]  step,
    output logic        cordic_start,
    output logic [15:0] cordic_angle,
    input  logic [15:0] cordic_sin,
    input  logic [15:0] cordic_cos,
    input  logic        cordic_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_angle,
    output logic [15:0] out_sin,
    output logic [15:0] out_cos,
    output logic        sweep_done,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [9:0]  r_angle;
    logic [9:0]  r_step;
    logic [15:0] r_cordic_angle;
    logic        r_cordic_start;
    logic        r_busy;
    logic        r_out_valid;
    logic [8:0]  r_out_angle;
    logic [15:0] r_out_sin;
    logic [15:0] r_out_cos;

    logic [9:0]  w_start_ext;
    logic [9:0]  w_san_start;
    logic [9:0]  w_san_step;
    logic [9:0]  w_sum;
    logic [9:0]  w_next_angle;
    logic        w_closing;
    logic        w_handshake;
    logic        w_timeout;
    logic        w_cordic_start_nxt;
    logic        w_busy_nxt;
    logic        w_sweep_done;

    // Sanitised sweep parameters and the wrapping angle adder. The step is
    // at most 359, so one conditional subtract always lands in 0..359.
    assign w_start_ext  = {1'b0, start_angle};
    assign w_san_start  = (w_start_ext >= 10'd360) ? (w_start_ext - 10'd360) : w_start_ext;
    assign w_san_step   = (step == 9'd0)   ? 10'd1 :
                          (step > 9'd359)  ? 10'd359 : {1'b0, step};
    assign w_sum        = r_angle + r_step;
    assign w_closing    = (w_sum >= 10'd360);
    assign w_next_angle = w_closing ? (w_sum - 10'd360) : w_sum;
    assign w_handshake  = (r_state == S_EMIT) && r_out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; cordic_done is only looked at in WAIT so a stale
    // done level from the previous request is skipped by the ARM cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = S_ISSUE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: w_next_state = S_ARM;
            S_ARM:   w_next_state = S_WAIT;
            S_WAIT: begin
                if (cordic_done || w_timeout) begin
                    w_next_state = S_EMIT;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_EMIT: begin
                if (w_handshake) begin
                    if (run && (continuous || !w_closing)) begin
                        w_next_state = S_ISSUE;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_EMIT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: request pulse and busy are registered from the next
    // state; sweep_done marks the handshake of the revolution-closing sample.
    always_comb begin
        w_cordic_start_nxt = (w_next_state == S_ISSUE);
        w_busy_nxt         = (w_next_state != S_IDLE);
        w_sweep_done       = w_handshake && w_closing;
    end

    // Datapath: angle/step latch, request angle, sample capture and release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_angle        <= 10'd0;
            r_step         <= 10'd0;
            r_cordic_angle <= 16'd0;
            r_cordic_start <= 1'b0;
            r_busy         <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_angle    <= 9'd0;
            r_out_sin      <= 16'd0;
            r_out_cos      <= 16'd0;
        end else begin
            r_cordic_start <= w_cordic_start_nxt;
            r_busy         <= w_busy_nxt;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_angle        <= w_san_start;
                        r_step         <= w_san_step;
                        r_cordic_angle <= {6'd0, w_san_start};
                    end
                end
                S_WAIT: begin
                    if (cordic_done) begin
                        r_out_sin   <= cordic_sin;
                        r_out_cos   <= cordic_cos;
                        r_out_angle <= r_angle[8:0];
                        r_out_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_out_sin   <= 16'd0;
                        r_out_cos   <= 16'd0;
                        r_out_angle <= r_angle[8:0];
                        r_out_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_angle     <= w_next_angle;
                        if (w_next_state == S_ISSUE) begin
                            r_cordic_angle <= {6'd0, w_next_angle};
                        end
                    end
                end
                default: begin
                    r_out_valid <= r_out_valid;
                end
            endcase
        end
    end

`ifdef SWEEP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout_err;

    assign w_timeout = (r_state == S_WAIT) && !cordic_done &&
                       (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // WAIT cycle counter, restarted every time WAIT is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= {CW{1'b0}};
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end else begin
            r_wait_cnt <= {CW{1'b0}};
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign cordic_start = r_cordic_start;
    assign cordic_angle = r_cordic_angle;
    assign out_valid    = r_out_valid;
    assign out_angle    = r_out_angle;
    assign out_sin      = r_out_sin;
    assign out_cos      = r_out_cos;
    assign sweep_done   = w_sweep_done;
    assign busy         = r_busy;

endmodule

// File: tb/tb_cordic_angle_sweeper.sv
// Testbench for cordic_angle_sweeper: a CORDIC stub answers 20 cycles after
// each start with sin=angle, cos=~angle; expected sample sequences come from
// a modulo-360 reference model of the sweep.
module tb_cordic_angle_sweeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        continuous;
    logic [8:0]  start_angle;
    logic [8:0]  step;
    logic        cordic_start;
    logic [15:0] cordic_angle;
    logic [15:0] cordic_sin;
    logic [15:0] cordic_cos;
    logic        cordic_done;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_angle;
    logic [15:0] out_sin;
    logic [15:0] out_cos;
    logic        sweep_done;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    logic        stub_mute = 1'b0;
    int          stub_cnt;
    logic [15:0] stub_ang;
    int          n_starts;

    cordic_angle_sweeper #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .run(run), .continuous(continuous),
        .start_angle(start_angle), .step(step),
        .cordic_start(cordic_start), .cordic_angle(cordic_angle),
        .cordic_sin(cordic_sin), .cordic_cos(cordic_cos), .cordic_done(cordic_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_angle(out_angle),
        .out_sin(out_sin), .out_cos(out_cos), .sweep_done(sweep_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // CORDIC stub: done drops on a start and rises 20 cycles later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cordic_done <= 1'b0;
            cordic_sin  <= 16'd0;
            cordic_cos  <= 16'd0;
            stub_cnt    <= 0;
            stub_ang    <= 16'd0;
            n_starts    <= 0;
        end else if (cordic_start) begin
            cordic_done <= 1'b0;
            stub_cnt    <= stub_mute ? 0 : 20;
            stub_ang    <= cordic_angle;
            n_starts    <= n_starts + 1;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                cordic_done <= 1'b1;
                cordic_sin  <= stub_ang;
                cordic_cos  <= ~stub_ang;
            end
        end
    end

    // Reference model of the sweep parameters.
    function automatic int model_start(input int s);
        return s % 360;
    endfunction

    function automatic int model_step(input int s);
        if (s == 0) return 1;
        if (s > 359) return 359;
        return s;
    endfunction

    // Bounded wait for the next sample; reports whether the bound expired.
    task automatic wait_valid(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (out_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic start_sweep(input int s, input int st, input logic cont);
        @(negedge clk);
        start_angle = 9'(s);
        step        = 9'(st);
        continuous  = cont;
        out_ready   = 1'b1;
        run         = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; continuous = 1'b0;
        start_angle = 9'd0; step = 9'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cordic_start, cordic_angle, out_valid, out_angle} !== 27'd0) begin
            errors++;
            $display("FAIL reset_req_out: got start=%0b angle=%0d valid=%0b oangle=%0d, want all 0",
                     cordic_start, cordic_angle, out_valid, out_angle);
        end
        checks++;
        if ({out_sin, out_cos, sweep_done, busy, timeout_err} !== 35'd0) begin
            errors++;
            $display("FAIL reset_misc: got sin=%h cos=%h sd=%0b busy=%0b terr=%0b, want all 0",
                     out_sin, out_cos, sweep_done, busy, timeout_err);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_one_shot();
        int exp_a[4] = '{0, 90, 180, 270};
        bit exp_d[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit to;
        int s0;
        s0 = n_starts;
        start_sweep(0, 90, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_valid(to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL oneshot_timeout: sample %0d never became valid", k);
                break;
            end
            if (k == 3) run = 1'b0;
            checks++;
            if (out_angle !== 9'(exp_a[k]) || out_sin !== 16'(exp_a[k]) ||
                out_cos !== ~16'(exp_a[k])) begin
                errors++;
                $display("FAIL oneshot_sample%0d: got a=%0d s=%h c=%h, want a=%0d s=%h c=%h", k,
                         out_angle, out_sin, out_cos, exp_a[k], 16'(exp_a[k]), ~16'(exp_a[k]));
            end
            checks++;
            if (sweep_done !== exp_d[k]) begin
                errors++;
                $display("FAIL oneshot_done%0d: got %0b want %0b", k, sweep_done, exp_d[k]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_idle: got busy=%0b valid=%0b want 0 0", busy, out_valid);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (n_starts - s0 !== 4) begin
            errors++;
            $display("FAIL oneshot_starts: got %0d requests want 4", n_starts - s0);
        end
    endtask

    // One-shot sweeps from model-derived tables; optionally stops early.
    task automatic run_model_sweep(input int s, input int st, input int max_n, input string nm);
        int a, sst, n;
        int exp_a[$];
        bit exp_d[$];
        bit to, cl;
        a = model_start(s);
        sst = model_step(st);
        do begin
            cl = (a + sst >= 360);
            exp_a.push_back(a);
            exp_d.push_back(cl);
            a = (a + sst) % 360;
        end while (!cl && exp_a.size() < max_n);
        n = exp_a.size();
        start_sweep(s, st, 1'b0);
        for (int k = 0; k < n; k++) begin
            wait_valid(to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL %s_timeout: sample %0d never valid", nm, k);
                break;
            end
            if (k == n - 1) run = 1'b0;
            checks++;
            if (out_angle !== 9'(exp_a[k]) || out_sin !== 16'(exp_a[k]) ||
                out_cos !== ~16'(exp_a[k]) || sweep_done !== exp_d[k]) begin
                errors++;
                $display("FAIL %s_sample%0d (start=%0d step=%0d): got a=%0d s=%h c=%h sd=%0b, want a=%0d sd=%0b",
                         nm, k, s, st, out_angle, out_sin, out_cos, sweep_done, exp_a[k], exp_d[k]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got busy=%0b want 0", nm, busy);
        end
    endtask

    task automatic test_sanitize();
        run_model_sweep(400, 0, 3, "sanitize_step0");
        run_model_sweep(359, 511, 8, "sanitize_bigstep");
        run_model_sweep(360, 359, 8, "sanitize_start360");
    endtask

    task automatic test_random_sweeps();
        for (int it = 0; it < 6; it++) begin
            run_model_sweep(int'($urandom_range(0, 511)), int'($urandom_range(40, 511)), 20, "random");
        end
    endtask

    task automatic test_backpressure();
        bit to, unstable, extra;
        logic [8:0] a0;
        logic [15:0] s0, c0;
        int st0;
        start_sweep(100, 120, 1'b0);
        out_ready = 1'b0;
        wait_valid(to);
        checks++;
        if (to || out_angle !== 9'd100) begin
            errors++;
            $display("FAIL bp_first: got timeout=%0b a=%0d want 0 100", to, out_angle);
        end
        a0 = out_angle; s0 = out_sin; c0 = out_cos; st0 = n_starts;
        unstable = 1'b0; extra = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_angle !== a0 || out_sin !== s0 || out_cos !== c0)
                unstable = 1'b1;
            if (n_starts != st0 || cordic_start !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL bp_stable: outputs changed, now valid=%0b a=%0d, want 1 %0d", out_valid, out_angle, a0);
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL bp_no_start: got %0d extra requests want 0", n_starts - st0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got valid=%0b after handshake want 0", out_valid);
        end
        wait_valid(to);
        checks++;
        if (to || out_angle !== 9'd220) begin
            errors++;
            $display("FAIL bp_next: got timeout=%0b a=%0d want 0 220", to, out_angle);
        end
        wait_valid(to);
        run = 1'b0;
        checks++;
        if (to || out_angle !== 9'd340 || sweep_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_last: got timeout=%0b a=%0d sd=%0b want 0 340 1", to, out_angle, sweep_done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_continuous_wrap();
        int exp_a[3] = '{350, 10, 30};
        bit exp_d[3] = '{1'b1, 1'b0, 1'b0};
        bit to, seen;
        int st0;
        start_sweep(350, 20, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_valid(to);
            checks++;
            if (to || out_angle !== 9'(exp_a[k]) || sweep_done !== exp_d[k]) begin
                errors++;
                $display("FAIL cont_sample%0d: got timeout=%0b a=%0d sd=%0b want 0 %0d %0b",
                         k, to, out_angle, sweep_done, exp_a[k], exp_d[k]);
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cordic_start) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || cordic_angle !== 16'd50) begin
            errors++;
            $display("FAIL cont_issue: got seen=%0b angle=%0d want 1 50", seen, cordic_angle);
        end
        repeat (5) @(negedge clk);
        run = 1'b0;
        wait_valid(to);
        checks++;
        if (to || out_angle !== 9'd50 || out_sin !== 16'd50 || sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop_sample: got timeout=%0b a=%0d s=%h sd=%0b want 0 50 0032 0",
                     to, out_angle, out_sin, sweep_done);
        end
        st0 = n_starts;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop_idle: got busy=%0b want 0", busy);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (n_starts != st0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop_quiet: got %0d extra requests terr=%0b want 0 0", n_starts - st0, timeout_err);
        end
        continuous = 1'b0;
    endtask

`ifdef SWEEP_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        int n;
        logic terr_before;
        stub_mute = 1'b1;
        start_sweep(0, 90, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cordic_start) begin
                seen = 1'b1;
                break;
            end
        end
        n = 0;
        terr_before = 1'b1;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (i == 65) terr_before = timeout_err;
            if (out_valid) begin
                n = i;
                break;
            end
        end
        checks++;
        if (!seen || n != 66 || terr_before !== 1'b0) begin
            errors++;
            $display("FAIL to_latency: got seen=%0b cycles=%0d terr_before=%0b want 1 66 0", seen, n, terr_before);
        end
        checks++;
        if (timeout_err !== 1'b1 || out_sin !== 16'd0 || out_cos !== 16'd0 || out_angle !== 9'd0) begin
            errors++;
            $display("FAIL to_sample: got terr=%0b s=%h c=%h a=%0d want 1 0000 0000 0",
                     timeout_err, out_sin, out_cos, out_angle);
        end
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cordic_start, cordic_angle, out_valid, out_angle, out_sin, out_cos,
             sweep_done, busy, timeout_err} !== 62'd0) begin
            errors++;
            $display("FAIL to_reset: got busy=%0b valid=%0b terr=%0b angle=%0d want all 0",
                     busy, out_valid, timeout_err, cordic_angle);
        end
        run = 1'b0;
        stub_mute = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one_shot();
        test_sanitize();
        test_random_sweeps();
        test_backpressure();
        test_continuous_wrap();
`ifdef SWEEP_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
